// File: rtl/pong_pkg.sv
// Definitions shared across the pong blocks: phase encoding, score width and side codes.
package pong_pkg;

    localparam int SCORE_W = 4;

    localparam logic SIDE_P1 = 1'b0;
    localparam logic SIDE_P2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

endpackage

// File: rtl/frame_delay_counter.sv
// Frame-tick countdown used by both the serve and the post-point pauses.
module frame_delay_counter #(
    parameter int DELAY_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DELAY_W-1:0] load_value,
    input  logic               tick,
    output logic               done
);

    logic [DELAY_W-1:0] count_reg;

    // A load always beats a tick arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (tick && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/game_controller.sv
// Pong match sequencer: serve/play/point/game-over phases, score keeping, paced by frame ticks.
module game_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 5,
    parameter int SCORE_W     = pong_pkg::SCORE_W,
    parameter int SERVE_DELAY = 60,
    parameter int POINT_DELAY = 30,
    parameter int DELAY_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               pause,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               reset_game,
    output logic               ball_en,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state
);

    localparam logic [SCORE_W-1:0] WIN_VALUE  = SCORE_W'(WIN_SCORE);
    localparam logic [DELAY_W-1:0] SERVE_LOAD = DELAY_W'(SERVE_DELAY);
    localparam logic [DELAY_W-1:0] POINT_LOAD = DELAY_W'(POINT_DELAY);

    state_t             state_reg, state_next;
    logic [SCORE_W-1:0] score_p1_reg, score_p1_next;
    logic [SCORE_W-1:0] score_p2_reg, score_p2_next;
    logic               serve_dir_reg, serve_dir_next;
    logic               winner_reg, winner_next;
    logic               game_over_reg, game_over_next;
    logic               reset_game_reg, reset_game_next;
    logic               ball_en_reg, ball_en_next;
    logic               cnt_load, cnt_tick, cnt_done;
    logic [DELAY_W-1:0] cnt_value;
    logic [SCORE_W-1:0] p1_inc, p2_inc;

    assign p1_inc   = score_p1_reg + 1'b1;
    assign p2_inc   = score_p2_reg + 1'b1;
    assign cnt_tick = frame_tick && ((state_reg == ST_SERVE) || (state_reg == ST_POINT));

    frame_delay_counter #(
        .DELAY_W(DELAY_W)
    ) u_delay (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .tick       (cnt_tick),
        .done       (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            score_p1_reg   <= '0;
            score_p2_reg   <= '0;
            serve_dir_reg  <= SIDE_P1;
            winner_reg     <= SIDE_P1;
            game_over_reg  <= 1'b0;
            reset_game_reg <= 1'b1;
            ball_en_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            score_p1_reg   <= score_p1_next;
            score_p2_reg   <= score_p2_next;
            serve_dir_reg  <= serve_dir_next;
            winner_reg     <= winner_next;
            game_over_reg  <= game_over_next;
            reset_game_reg <= reset_game_next;
            ball_en_reg    <= ball_en_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        score_p1_next  = score_p1_reg;
        score_p2_next  = score_p2_reg;
        serve_dir_next = serve_dir_reg;
        winner_next    = winner_reg;
        game_over_next = game_over_reg;
        cnt_load       = 1'b0;
        cnt_value      = SERVE_LOAD;

        case (state_reg)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    score_p1_next  = '0;
                    score_p2_next  = '0;
                    serve_dir_next = SIDE_P1;
                    game_over_next = 1'b0;
                    cnt_load       = 1'b1;
                    state_next     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (frame_tick && cnt_done) begin
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A pause freezes the rally, so misses seen while paused are dropped.
                if (!pause) begin
                    if (miss_left && miss_right) begin
                        cnt_load   = 1'b1;
                        cnt_value  = POINT_LOAD;
                        state_next = ST_POINT;
                    end else if (miss_left) begin
                        score_p2_next  = p2_inc;
                        serve_dir_next = SIDE_P1;
                        if (p2_inc == WIN_VALUE) begin
                            winner_next    = SIDE_P2;
                            game_over_next = 1'b1;
                            state_next     = ST_GAME_OVER;
                        end else begin
                            cnt_load   = 1'b1;
                            cnt_value  = POINT_LOAD;
                            state_next = ST_POINT;
                        end
                    end else if (miss_right) begin
                        score_p1_next  = p1_inc;
                        serve_dir_next = SIDE_P2;
                        if (p1_inc == WIN_VALUE) begin
                            winner_next    = SIDE_P1;
                            game_over_next = 1'b1;
                            state_next     = ST_GAME_OVER;
                        end else begin
                            cnt_load   = 1'b1;
                            cnt_value  = POINT_LOAD;
                            state_next = ST_POINT;
                        end
                    end
                end
            end
            ST_POINT: begin
                if (frame_tick && cnt_done) begin
                    cnt_load   = 1'b1;
                    state_next = ST_SERVE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Paddles and ball are held centred whenever the rally is not live or cooling down.
        reset_game_next = (state_next != ST_PLAY) && (state_next != ST_POINT);
        ball_en_next    = (state_next == ST_PLAY) && !pause;
    end

    assign state      = state_reg;
    assign score_p1   = score_p1_reg;
    assign score_p2   = score_p2_reg;
    assign serve_dir  = serve_dir_reg;
    assign winner     = winner_reg;
    assign game_over  = game_over_reg;
    assign reset_game = reset_game_reg;
    assign ball_en    = ball_en_reg;

endmodule

// File: tb/tb_game_controller.sv
// Directed match scenarios followed by random stimulus, checked against a rule-level match model.
module tb_game_controller;

    localparam int WIN   = 3;
    localparam int SD    = 3;
    localparam int PD    = 2;
    localparam int SW    = 4;

    logic          clk = 1'b0;
    logic          reset, frame_tick, start, pause, miss_left, miss_right;
    logic          reset_game, ball_en, serve_dir, game_over, winner;
    logic [SW-1:0] score_p1, score_p2;
    logic [2:0]    state;

    int errors = 0;
    int checks = 0;
    int n_step = 0;

    // Match model: phase number, scores and frame ticks still to wait in the current pause.
    int m_phase, m_p1, m_p2, m_dir, m_over, m_win, m_ticks_left, m_rg, m_be;

    game_controller #(
        .WIN_SCORE   (WIN),
        .SCORE_W     (SW),
        .SERVE_DELAY (SD),
        .POINT_DELAY (PD),
        .DELAY_W     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .pause      (pause),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .reset_game (reset_game),
        .ball_en    (ball_en),
        .serve_dir  (serve_dir),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .game_over  (game_over),
        .winner     (winner),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, n_step, obs, exp);
        end
    endtask

    task automatic new_match();
        m_p1 = 0; m_p2 = 0; m_dir = 0; m_over = 0;
        m_phase = 1; m_ticks_left = SD + 1;
    endtask

    task automatic score(input int side);
        // side 0: p1 scored, side 1: p2 scored
        if (side == 0) m_p1++; else m_p2++;
        m_dir = (side == 0) ? 1 : 0;
        if ((side == 0 ? m_p1 : m_p2) == WIN) begin
            m_phase = 4; m_over = 1; m_win = side;
        end else begin
            m_phase = 3; m_ticks_left = PD + 1;
        end
    endtask

    task automatic model(input bit rst, st, tk, pa, ml, mr);
        if (rst) begin
            m_phase = 0; m_p1 = 0; m_p2 = 0; m_dir = 0;
            m_over = 0; m_win = 0; m_ticks_left = 0;
        end else if (m_phase == 0 || m_phase == 4) begin
            if (st) new_match();
        end else if (m_phase == 1 || m_phase == 3) begin
            if (tk) begin
                m_ticks_left--;
                if (m_ticks_left == 0) begin
                    if (m_phase == 1) m_phase = 2;
                    else begin m_phase = 1; m_ticks_left = SD + 1; end
                end
            end
        end else if (!pa) begin
            if (ml && mr) begin
                m_phase = 3; m_ticks_left = PD + 1;
            end else if (ml) score(1);
            else if (mr) score(0);
        end
        m_rg = (m_phase == 2 || m_phase == 3) ? 0 : 1;
        m_be = (m_phase == 2 && !pa) ? 1 : 0;
    endtask

    task automatic step(input bit rst, st, tk, pa, ml, mr);
        reset = rst; start = st; frame_tick = tk; pause = pa;
        miss_left = ml; miss_right = mr;
        model(rst, st, tk, pa, ml, mr);
        @(posedge clk);
        #1;
        n_step++;
        $display("step %0d in rst=%0d st=%0d tk=%0d pa=%0d ml=%0d mr=%0d -> state=%0d p1=%0d p2=%0d dir=%0d rg=%0d be=%0d go=%0d win=%0d",
                 n_step, rst, st, tk, pa, ml, mr, state, score_p1, score_p2,
                 serve_dir, reset_game, ball_en, game_over, winner);
        chk("state", int'(state), m_phase);
        chk("score_p1", int'(score_p1), m_p1);
        chk("score_p2", int'(score_p2), m_p2);
        chk("serve_dir", int'(serve_dir), m_dir);
        chk("reset_game", int'(reset_game), m_rg);
        chk("ball_en", int'(ball_en), m_be);
        chk("game_over", int'(game_over), m_over);
        if (m_over == 1) chk("winner", int'(winner), m_win);
    endtask

    // Idle cycles then one tick, repeated n times.
    task automatic ticks(input int n, input bit pa);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, pa, 0, 0);
            step(0, 0, 1, pa, 0, 0);
        end
    endtask

    initial begin
        reset = 1; start = 0; frame_tick = 0; pause = 0; miss_left = 0; miss_right = 0;

        // Reset and idle
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("reset_state", int'(state), 0);
        chk("reset_rg", int'(reset_game), 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);

        // Start and serve delay: the fourth tick launches the ball
        step(0, 1, 0, 0, 0, 0);
        chk("serve_entry", int'(state), 1);
        for (int t = 1; t <= 4; t++) begin
            for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
            step(0, 0, 1, 0, 0, 0);
            if (t == 3) chk("serve_hold", int'(state), 1);
        end
        chk("play_state", int'(state), 2);
        chk("play_ball_en", int'(ball_en), 1);
        chk("play_rg", int'(reset_game), 0);

        // p1 scores, point pause, back to serve and play
        step(0, 0, 0, 0, 0, 1);
        chk("mr_p1", int'(score_p1), 1);
        chk("mr_dir", int'(serve_dir), 1);
        chk("mr_state", int'(state), 3);
        ticks(3, 0);
        chk("point_exit", int'(state), 1);
        ticks(4, 0);
        chk("serve_exit", int'(state), 2);

        // Simultaneous misses: no score, point pause
        step(0, 0, 0, 0, 1, 1);
        chk("both_state", int'(state), 3);
        chk("both_p1", int'(score_p1), 1);
        chk("both_p2", int'(score_p2), 0);
        ticks(7, 0);

        // Pause masks misses and stops the ball
        step(0, 0, 0, 1, 0, 0);
        chk("pause_be", int'(ball_en), 0);
        step(0, 0, 0, 1, 1, 0);
        chk("pause_p2", int'(score_p2), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("unpause_be", int'(ball_en), 1);

        // p2 reaches the winning score
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 1, 0);
            if (k < 2) ticks(7, 0);
        end
        chk("win_state", int'(state), 4);
        chk("win_go", int'(game_over), 1);
        chk("win_who", int'(winner), 1);
        chk("win_rg", int'(reset_game), 1);
        step(0, 0, 0, 0, 1, 0);
        chk("go_hold_p2", int'(score_p2), 3);

        // Restart with a simultaneous tick: start wins
        step(0, 1, 1, 0, 0, 0);
        chk("restart_state", int'(state), 1);
        chk("restart_p2", int'(score_p2), 0);
        ticks(4, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_point_state", int'(state), 0);
        chk("rst_point_p1", int'(score_p1), 0);
        chk("rst_point_rg", int'(reset_game), 1);

        // Random play against the model
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
